ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the

---
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx.sv | 166 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-byte handshake and transfer status between client and PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, done, ack_err, timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, done, ack_err, timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with ACK check and watchdog.
// Optional macro PS2_TX_RETRY_EN: resend a failed byte up to two more times.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ps2_host_tx_if.slave bus,
    input  logic         i_ps2_clk_in,
    input  logic         i_ps2_data_in,
    output logic         o_ps2_clk_oe,
    output logic         o_ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t r_state, w_next;

    logic          r_clk_m, r_clk_s, r_clk_d, r_dat_m, r_dat_s;
    logic [9:0]    r_shift;
    logic          r_data_oe;
    logic [3:0]    r_edges;
    logic [IW-1:0] r_inh;
    logic [WW-1:0] r_wd;
    logic          r_ack_bad, r_done, r_ack_err, r_timeout;
    logic          w_fall, w_inh_end, w_wd_on, w_wd_exp;
    logic          w_accept, w_fin, w_retry;
    logic [7:0]    w_byte;

    assign w_fall    = r_clk_d & ~r_clk_s;
    assign w_inh_end = (r_inh == IW'(INHIBIT_CYCLES - 1));
    assign w_wd_on   = (r_state == S_RTS) | (r_state == S_SHIFT) |
                       (r_state == S_ACK) | (r_state == S_WAIT_IDLE);
    assign w_wd_exp  = w_wd_on & ~w_fall & (r_wd == WW'(TIMEOUT_CYCLES - 1));
    assign w_accept  = bus.tx_valid & (r_state == S_IDLE);
    assign w_fin     = w_wd_exp |
                       ((r_state == S_WAIT_IDLE) & r_clk_s & r_dat_s);

`ifdef PS2_TX_RETRY_EN
    logic [7:0] r_byte;
    logic [1:0] r_tries;

    assign w_retry = w_fin & (w_wd_exp | r_ack_bad) & (r_tries != 2'd2);
    assign w_byte  = w_accept ? bus.tx_data : r_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte  <= '0;
            r_tries <= '0;
        end else if (w_accept) begin
            r_byte  <= bus.tx_data;
            r_tries <= '0;
        end else if (w_retry) begin
            r_tries <= r_tries + 2'd1;
        end
    end
`else
    assign w_retry = 1'b0;
    assign w_byte  = bus.tx_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        o_ps2_clk_oe  = 1'b0;
        o_ps2_data_oe = 1'b0;
        bus.tx_ready  = 1'b0;
        bus.tx_busy   = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                bus.tx_ready = 1'b1;
                bus.tx_busy  = 1'b0;
                if (w_accept) w_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                o_ps2_clk_oe = 1'b1;
                if (w_inh_end) w_next = S_RTS;
            end
            S_RTS: begin
                o_ps2_data_oe = r_data_oe;
                if (w_fall) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                o_ps2_data_oe = r_data_oe;
                if (w_fall && r_edges == 4'd9) w_next = S_ACK;
            end
            S_ACK: begin
                if (w_fall) w_next = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (r_clk_s && r_dat_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_wd_exp) w_next = S_IDLE;
        if (w_retry)  w_next = S_INHIBIT;
    end

    assign bus.done    = r_done;
    assign bus.ack_err = r_ack_err;
    assign bus.timeout = r_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_m   <= 1'b1;
            r_clk_s   <= 1'b1;
            r_clk_d   <= 1'b1;
            r_dat_m   <= 1'b1;
            r_dat_s   <= 1'b1;
            r_shift   <= '0;
            r_data_oe <= 1'b0;
            r_edges   <= '0;
            r_inh     <= '0;
            r_wd      <= '0;
            r_ack_bad <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_clk_m <= i_ps2_clk_in;
            r_clk_s <= r_clk_m;
            r_clk_d <= r_clk_s;
            r_dat_m <= i_ps2_data_in;
            r_dat_s <= r_dat_m;
            r_done  <= 1'b0;
            if (w_fall)       r_wd <= '0;
            else if (w_wd_on) r_wd <= r_wd + WW'(1);
            if (w_accept | w_retry) begin
                r_shift <= {1'b1, ~^w_byte, w_byte};
                r_inh   <= '0;
            end
            if (r_state == S_INHIBIT) begin
                r_inh <= r_inh + IW'(1);
                // start bit goes out the same cycle the clock is released
                if (w_inh_end) begin
                    r_data_oe <= 1'b1;
                    r_wd      <= '0;
                    r_edges   <= '0;
                    r_ack_bad <= 1'b0;
                end
            end
            if (w_fall && w_wd_on && r_edges != 4'd11)
                r_edges <= r_edges + 4'd1;
            if (w_fall && (r_state == S_RTS || r_state == S_SHIFT)) begin
                r_data_oe <= ~r_shift[0];
                r_shift   <= {1'b1, r_shift[9:1]};
            end
            if (w_fall && r_state == S_ACK)
                r_ack_bad <= r_dat_s;
            if (w_fin && !w_retry) begin
                r_done    <= 1'b1;
                r_ack_err <= r_ack_bad & ~w_wd_exp;
                r_timeout <= w_wd_exp;
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model and
// a per-cycle status model for ps2_host_tx.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TO  = 500;
    localparam int H   = 10;
`ifdef PS2_TX_RETRY_EN
    localparam int NTRY = 3;
`else
    localparam int NTRY = 1;
`endif

    typedef struct packed {
        logic ack;
        logic to;
    } exp_t;

    logic clk, rst;
    logic clk_oe, data_oe;
    logic dev_clk, dev_data;
    wire  clk_line  = ~(clk_oe | dev_clk);
    wire  data_line = ~(data_oe | dev_data);

    ps2_host_tx_if bus ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus),
        .i_ps2_clk_in(clk_line),
        .i_ps2_data_in(data_line),
        .o_ps2_clk_oe(clk_oe),
        .o_ps2_data_oe(data_oe)
    );

    int   n_pass = 0, n_fail = 0;
    int   cyc = 0, n_frames = 0, n_done = 0, last_done_cyc = 0;
    int   t_fall = 0;
    logic [1:0] done_oe;
    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        if (act >= lo && act <= hi) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // compare process: status outputs vs expected-outcome queue, every cycle
    initial begin
        logic last_ack, last_to, prev_done, prev_coe;
        int   inh_len;
        exp_t e;
        last_ack = 0; last_to = 0; prev_done = 0; prev_coe = 0; inh_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_ack = 0; last_to = 0; prev_done = 0;
                prev_coe = 0; inh_len = 0;
            end else begin
                chk("busy_not_ready", bus.tx_busy, !bus.tx_ready);
                chk("oe_exclusive", clk_oe & data_oe, 0);
                if (clk_oe && !prev_coe) n_frames++;
                if (clk_oe) inh_len++;
                else if (inh_len != 0) begin
                    chk("inhibit_len", inh_len, INH);
                    inh_len = 0;
                end
                if (bus.done) begin
                    n_done++;
                    last_done_cyc = cyc;
                    done_oe = {clk_oe, data_oe};
                    chk("done_single_pulse", prev_done, 0);
                    chk("ready_in_done", bus.tx_ready, 1);
                    if (exp_q.size() == 0) chk("done_unexpected", bus.done, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("ack_err", bus.ack_err, e.ack);
                        chk("timeout", bus.timeout, e.to);
                        last_ack = e.ack;
                        last_to  = e.to;
                    end
                end else begin
                    chk("ack_err_hold", bus.ack_err, last_ack);
                    chk("timeout_hold", bus.timeout, last_to);
                end
                prev_done = bus.done;
                prev_coe  = clk_oe;
            end
        end
    end

    task automatic dev_frame(input int nfalls, input bit do_ack,
                             input logic [9:0] exp_frame, input string tag);
        logic [9:0] bits;
        int w;
        bits = '0;
        w = 0;
        while (clk_line && w < 2000) begin step(1); w++; end
        if (clk_line) begin chk({tag, "_inhibit_seen"}, clk_line, 0); return; end
        w = 0;
        while (!clk_line && w < 2000) begin step(1); w++; end
        if (!clk_line) begin chk({tag, "_clk_release"}, clk_line, 1); return; end
        chk({tag, "_start_bit"}, data_line, 0);
        for (int k = 1; k <= nfalls; k++) begin
            step(H);
            dev_clk = 1'b1;
            t_fall = cyc;
            step(H);
            dev_clk = 1'b0;
            if (k <= 10) bits[k-1] = data_line;
            if (k == 10 && do_ack) dev_data = 1'b1;
        end
        step(H);
        dev_data = 1'b0;
        if (nfalls >= 10) chk({tag, "_frame"}, bits, exp_frame);
    endtask

    task automatic send(input logic [7:0] d);
        chk("ready_before_send", bus.tx_ready, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int nd0, input string tag);
        int w = 0;
        while (n_done <= nd0 && w < 3000) begin @(negedge clk); w++; end
        chk({tag, "_done_count"}, n_done, nd0 + 1);
    endtask

    initial begin
        int nd0, f0;
        rst = 1'b1; dev_clk = 1'b0; dev_data = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.tx_ready, 1);
        chk("rst_busy", bus.tx_busy, 0);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ack_err", bus.ack_err, 0);
        chk("rst_timeout", bus.timeout, 0);
        step(1);

        // 1: 0xED acked
        exp_q.push_back('{ack: 0, to: 0});
        nd0 = n_done; f0 = n_frames;
        fork
            send(8'hED);
            dev_frame(11, 1, 10'h3ED, "t1");
        join
        wait_done(nd0, "t1");
        chk("t1_frames", n_frames - f0, 1);
        step(5);

        // 2: parity of 0x01 and 0x00
        exp_q.push_back('{ack: 0, to: 0});
        nd0 = n_done;
        fork
            send(8'h01);
            dev_frame(11, 1, 10'h201, "t2a");
        join
        wait_done(nd0, "t2a");
        step(5);
        exp_q.push_back('{ack: 0, to: 0});
        nd0 = n_done;
        fork
            send(8'h00);
            dev_frame(11, 1, 10'h300, "t2b");
        join
        wait_done(nd0, "t2b");
        step(5);

        // 3: device never acks
        exp_q.push_back('{ack: 1, to: 0});
        nd0 = n_done; f0 = n_frames;
        fork
            send(8'hA5);
            repeat (NTRY) dev_frame(11, 0, frame_of(8'hA5), "t3");
        join
        wait_done(nd0, "t3");
        chk("t3_frames", n_frames - f0, NTRY);
        step(5);

        // 4: device stops clocking after fall 4
        exp_q.push_back('{ack: 0, to: 1});
        nd0 = n_done; f0 = n_frames;
        fork
            send(8'hF0);
            repeat (NTRY) dev_frame(4, 1, 10'h000, "t4");
        join
        wait_done(nd0, "t4");
        chk_rng("t4_timeout_delay", last_done_cyc - t_fall, TO, TO + 6);
        chk("t4_oe_at_done", done_oe, 2'b00);
        chk("t4_frames", n_frames - f0, NTRY);
        step(5);

        // 5: reset mid-frame after fall 6
        nd0 = n_done;
        fork
            send(8'h3C);
            dev_frame(6, 1, 10'h000, "t5");
        join
        step(2);
        chk("t5_busy_before_rst", bus.tx_busy, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_clk_oe", clk_oe, 0);
        chk("t5_data_oe", data_oe, 0);
        chk("t5_ready", bus.tx_ready, 1);
        step(40);
        chk("t5_no_done", n_done, nd0);

        // 6: held tx_valid, back-to-back in done cycle, busy pulses ignored
        exp_q.push_back('{ack: 0, to: 0});
        exp_q.push_back('{ack: 0, to: 0});
        nd0 = n_done; f0 = n_frames;
        fork
            begin
                int w;
                bus.tx_data = 8'h55;
                bus.tx_valid = 1'b1;
                step(1);
                chk("t6_first_taken", bus.tx_busy, 1);
                bus.tx_data = 8'hF4;
                w = 0;
                do begin @(negedge clk); w++; end while (!bus.done && w < 3000);
                chk("t6_ready_in_done", bus.tx_ready, 1);
                step(1);
                bus.tx_valid = 1'b0;
                bus.tx_data  = 8'hAA;
                @(negedge clk);
                chk("t6_b2b_taken", bus.tx_busy, 1);
                step(30);
                chk("t6_busy_pulse1", bus.tx_busy, 1);
                bus.tx_valid = 1'b1;
                step(1);
                bus.tx_valid = 1'b0;
                step(100);
                chk("t6_busy_pulse2", bus.tx_busy, 1);
                bus.tx_valid = 1'b1;
                step(1);
                bus.tx_valid = 1'b0;
            end
            begin
                dev_frame(11, 1, frame_of(8'h55), "t6a");
                dev_frame(11, 1, frame_of(8'hF4), "t6b");
            end
        join
        wait_done(nd0 + 1, "t6");
        step(100);
        chk("t6_frames", n_frames - f0, 2);
        chk("t6_idle_after", bus.tx_ready, 1);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
